// File: rtl/axi4l_stream_bridge_if.sv
// rtl/axi4l_stream_bridge_if.sv - AXI4-Lite register bus plus TX/RX sample streams
interface axi4l_stream_bridge_if;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output m_tdata, m_tvalid, input m_tready,
        input  s_tdata, s_tvalid, output s_tready
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  m_tdata, m_tvalid, output m_tready,
        output s_tdata, s_tvalid, input s_tready
    );
endinterface

// File: rtl/axi4l_stream_bridge.sv
// rtl/axi4l_stream_bridge.sv - AXI4-Lite to TX/RX stream FIFO bridge; AXI4L_STREAM_IRQ_EN adds irq output
module axi4l_stream_bridge #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESETN,
    axi4l_stream_bridge_if.slave bus
`ifdef AXI4L_STREAM_IRQ_EN
    ,
    output logic irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
`ifdef AXI4L_STREAM_IRQ_EN
    localparam logic [3:0]    CTRL_MASK = 4'hF;
    localparam logic [LW-1:0] HALF_LVL  = LW'(FIFO_DEPTH / 2);
`else
    localparam logic [3:0]    CTRL_MASK = 4'h7;
`endif

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic          aw_wready_q, aw_wready_d, bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
    logic [LW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [LW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic          s_tready_q, s_tready_d;
    logic [31:0]   tx_mem [FIFO_DEPTH];
    logic [31:0]   rx_mem [FIFO_DEPTH];

    logic [LW-1:0] tx_level, rx_level, rx_level_d;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          do_write, do_read, tx_push, tx_pop, rx_push, rx_pop;
    logic          tx_ovf_set, rx_unf_set;
    logic [1:0]    wr_sel, rd_sel;
    logic [31:0]   status;
    logic          unused_bits;

    assign tx_level = tx_wr_q - tx_rd_q;
    assign rx_level = rx_wr_q - rx_rd_q;
    assign tx_full  = (tx_level == FULL_LVL);
    assign tx_empty = (tx_level == '0);
    assign rx_full  = (rx_level == FULL_LVL);
    assign rx_empty = (rx_level == '0);
    assign wr_sel   = bus.S_AXI_AWADDR[3:2];
    assign rd_sel   = bus.S_AXI_ARADDR[3:2];

    // The AW/W handshake completes in W_ACK and the AR handshake in R_ADDR,
    // so those states are where register side effects happen.
    assign do_write   = (w_state_q == W_ACK);
    assign do_read    = (r_state_q == R_ADDR);
    assign tx_push    = do_write && (wr_sel == 2'd2) && !tx_full;
    assign tx_ovf_set = do_write && (wr_sel == 2'd2) && tx_full;
    assign rx_pop     = do_read && (rd_sel == 2'd3) && !rx_empty;
    assign rx_unf_set = do_read && (rd_sel == 2'd3) && rx_empty;
    assign tx_pop     = bus.m_tvalid && bus.m_tready;
    assign rx_push    = bus.s_tvalid && s_tready_q;

    assign bus.m_tvalid      = ctrl_q[0] && !tx_empty;
    assign bus.m_tdata       = tx_mem[tx_rd_q[AW-1:0]];
    assign bus.s_tready      = s_tready_q;
    assign bus.S_AXI_AWREADY = aw_wready_q;
    assign bus.S_AXI_WREADY  = aw_wready_q;
    assign bus.S_AXI_BVALID  = bvalid_q;
    assign bus.S_AXI_BRESP   = bresp_q;
    assign bus.S_AXI_ARREADY = arready_q;
    assign bus.S_AXI_RVALID  = rvalid_q;
    assign bus.S_AXI_RDATA   = rdata_q;
    assign bus.S_AXI_RRESP   = rresp_q;
    assign unused_bits = ^{bus.S_AXI_AWADDR[1:0], bus.S_AXI_ARADDR[1:0],
                           bus.S_AXI_WSTRB[3], bus.S_AXI_WSTRB[1], rx_full};

    always_comb begin
        status = '0;
        status[LW-1:0]  = tx_level;
        status[8 +: LW] = rx_level;
        status[16] = tx_full;
        status[17] = rx_empty;
        status[18] = tx_ovf_q;
        status[19] = rx_unf_q;
    end

    always_comb begin
        ctrl_d = {ctrl_q[3], 2'b00, ctrl_q[0]};
        if (do_write && wr_sel == 2'd0 && bus.S_AXI_WSTRB[0])
            ctrl_d = bus.S_AXI_WDATA[3:0] & CTRL_MASK;
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (do_write && wr_sel == 2'd1 && bus.S_AXI_WSTRB[2]) begin
            tx_ovf_d = tx_ovf_q & ~bus.S_AXI_WDATA[18];
            rx_unf_d = rx_unf_q & ~bus.S_AXI_WDATA[19];
        end
        tx_ovf_d = tx_ovf_d | tx_ovf_set;
        rx_unf_d = rx_unf_d | rx_unf_set;

        tx_wr_d = ctrl_q[1] ? '0 : tx_wr_q + LW'(tx_push);
        tx_rd_d = ctrl_q[1] ? '0 : tx_rd_q + LW'(tx_pop);
        rx_wr_d = ctrl_q[2] ? '0 : rx_wr_q + LW'(rx_push);
        rx_rd_d = ctrl_q[2] ? '0 : rx_rd_q + LW'(rx_pop);
        rx_level_d = rx_wr_d - rx_rd_d;
        s_tready_d = (rx_level_d != FULL_LVL);
    end

    always_comb begin
        w_state_d   = w_state_q;
        aw_wready_d = 1'b0;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        case (w_state_q)
            W_IDLE: if (bus.S_AXI_AWVALID && bus.S_AXI_WVALID) begin
                aw_wready_d = 1'b1;
                w_state_d   = W_ACK;
            end
            W_ACK: begin
                bvalid_d  = 1'b1;
                bresp_d   = tx_ovf_set ? 2'b10 : 2'b00;
                w_state_d = W_RESP;
            end
            W_RESP: if (bus.S_AXI_BREADY) begin
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: if (bus.S_AXI_ARVALID) begin
                arready_d = 1'b1;
                r_state_d = R_ADDR;
            end
            R_ADDR: begin
                rvalid_d = 1'b1;
                rresp_d  = rx_unf_set ? 2'b10 : 2'b00;
                case (rd_sel)
                    2'd0:    rdata_d = {28'b0, ctrl_q};
                    2'd1:    rdata_d = status;
                    2'd3:    rdata_d = rx_empty ? 32'b0 : rx_mem[rx_rd_q[AW-1:0]];
                    default: rdata_d = 32'b0;
                endcase
                r_state_d = R_DATA;
            end
            R_DATA: if (bus.S_AXI_RREADY) begin
                rvalid_d  = 1'b0;
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            aw_wready_q <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'b0;
            rresp_q     <= 2'b00;
            ctrl_q      <= 4'b0;
            tx_ovf_q    <= 1'b0;
            rx_unf_q    <= 1'b0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            s_tready_q  <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            aw_wready_q <= aw_wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            ctrl_q      <= ctrl_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_unf_q    <= rx_unf_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            s_tready_q  <= s_tready_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= bus.S_AXI_WDATA;
        if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= bus.s_tdata;
    end

`ifdef AXI4L_STREAM_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = ctrl_q[3] && ((rx_level >= HALF_LVL) || tx_ovf_q || rx_unf_q);
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) irq_q <= 1'b0;
        else                irq_q <= irq_d;
    end
    assign irq = irq_q;
`endif
endmodule
